// File: rtl/rtype_issuer_if.sv
// Bundles the command, core-facing and response signals of rtype_issuer.
// The slave modport is the issuer's view; the master modport is the environment's view.
interface rtype_issuer_if #(
  parameter int unsigned CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_funct3;
  logic             cmd_alt;
  logic [4:0]       cmd_rs1;
  logic [4:0]       cmd_rs2;
  logic [4:0]       cmd_rd;
  logic [31:0]      cmd_a;
  logic [31:0]      cmd_b;
  logic [31:0]      instruction;
  logic [31:0]      a;
  logic [31:0]      b;
  logic [31:0]      y;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_y;
  logic [31:0]      rsp_expected;
  logic             rsp_match;
  logic [CNT_W-1:0] issue_count;
  logic [CNT_W-1:0] err_count;

  modport master (
    output cmd_valid, cmd_funct3, cmd_alt, cmd_rs1, cmd_rs2, cmd_rd, cmd_a, cmd_b,
    output y, rsp_ready,
    input  cmd_ready, instruction, a, b,
    input  rsp_valid, rsp_y, rsp_expected, rsp_match, issue_count, err_count
  );

  modport slave (
    input  cmd_valid, cmd_funct3, cmd_alt, cmd_rs1, cmd_rs2, cmd_rd, cmd_a, cmd_b,
    input  y, rsp_ready,
    output cmd_ready, instruction, a, b,
    output rsp_valid, rsp_y, rsp_expected, rsp_match, issue_count, err_count
  );
endinterface

// File: rtl/rtype_issuer.sv
// Drives R-type ALU commands into the processor core, holds them HOLD_CYCLES,
// samples y and reports it against an internal ALU reference model.
module rtype_issuer #(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input logic           clk,
  input logic           rst,
  rtype_issuer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  localparam logic [7:0]  HOLD_M1 = 8'(HOLD_CYCLES - 1);
  localparam logic [31:0] NOP     = 32'h0000_0033;

  state_t           state_q;
  logic [7:0]       hold_q;
  logic             cmd_ready_q;
  logic             rsp_valid_q;
  logic [31:0]      instr_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [31:0]      rsp_y_q;
  logic [31:0]      rsp_exp_q;
  logic             rsp_match_q;
  logic [CNT_W-1:0] issue_q;
  logic [CNT_W-1:0] err_q;

  function automatic logic [31:0] encode(input logic [2:0] f3, input logic alt,
                                         input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [4:0] rd);
    logic [6:0] f7;
    f7 = (alt && (f3 == 3'b000 || f3 == 3'b101)) ? 7'b0100000 : 7'b0000000;
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] op_a, input logic [31:0] op_b);
    logic [31:0] r;
    case (f3)
      3'b000:  r = alt ? op_a - op_b : op_a + op_b;
      3'b001:  r = op_a << op_b[4:0];
      3'b010:  r = {31'd0, $signed(op_a) < $signed(op_b)};
      3'b011:  r = {31'd0, op_a < op_b};
      3'b100:  r = op_a ^ op_b;
      3'b101:  r = alt ? 32'($signed(op_a) >>> op_b[4:0]) : op_a >> op_b[4:0];
      3'b110:  r = op_a | op_b;
      default: r = op_a & op_b;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      instr_q     <= NOP;
      a_q         <= '0;
      b_q         <= '0;
      rsp_y_q     <= '0;
      rsp_exp_q   <= '0;
      rsp_match_q <= 1'b0;
      issue_q     <= '0;
      err_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            instr_q     <= encode(bus.cmd_funct3, bus.cmd_alt, bus.cmd_rs1, bus.cmd_rs2, bus.cmd_rd);
            a_q         <= bus.cmd_a;
            b_q         <= bus.cmd_b;
            rsp_exp_q   <= alu_ref(bus.cmd_funct3, bus.cmd_alt, bus.cmd_a, bus.cmd_b);
            hold_q      <= HOLD_M1;
            cmd_ready_q <= 1'b0;
            state_q     <= DRIVE;
          end
        end
        DRIVE: begin
          // y is sampled on the HOLD_CYCLES-th edge after the accept edge
          if (hold_q == '0) begin
            rsp_y_q     <= bus.y;
            rsp_match_q <= (bus.y == rsp_exp_q);
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            hold_q <= hold_q - 8'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            if (issue_q != '1) issue_q <= issue_q + CNT_W'(1);
            if (!rsp_match_q && err_q != '1) err_q <= err_q + CNT_W'(1);
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready    = cmd_ready_q;
  assign bus.instruction  = instr_q;
  assign bus.a            = a_q;
  assign bus.b            = b_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_y        = rsp_y_q;
  assign bus.rsp_expected = rsp_exp_q;
  assign bus.rsp_match    = rsp_match_q;
  assign bus.issue_count  = issue_q;
  assign bus.err_count    = err_q;

endmodule
